cache_coherence_hub: RTL and testbench
======================================

CACHE_COHERENCE_HUB -- requirements
Module: cache_coherence_hub

Interface
REQ-001 Parameter ADDR_WDT, default 32, coherence address width.
REQ-002 Parameter TIMEOUT_CYC, default 255, max cycles spent in WAIT_ACK; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 up_req_valid  input  4  per-L1 invalidation request (cache o_coherence_valid side); level, held until its up_req_ack.
REQ-006 up_req_addr  input  4*ADDR_WDT  per-L1 request address; port p at bits [p*ADDR_WDT +: ADDR_WDT]; stable while valid.
REQ-007 up_req_ack  output  4  one-cycle completion pulse to the originating L1.
REQ-008 dn_inv_valid  output  4  one-cycle invalidate pulse to each target L1 (cache i_coherence_valid side).
REQ-009 dn_inv_addr  output  ADDR_WDT  shared invalidate address, valid while dn_inv_valid is nonzero.
REQ-010 dn_inv_ack  input  4  per-target single-cycle acknowledge pulse (cache o_coherence_ack side).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err_timeout  output  1  sticky flag, set when a transaction completes by timeout.

Function
REQ-013 FSM states: IDLE, BCAST, WAIT_ACK, DONE; registered state, registered outputs.
REQ-014 IDLE: if any up_req_valid high, grant one port by round-robin starting at rr_ptr; latch owner and owner address; next state BCAST. Otherwise stay IDLE.
REQ-015 Round-robin: search order rr_ptr, rr_ptr+1, ... mod 4; after DONE, rr_ptr = owner+1 mod 4 (2-bit wrap).
REQ-016 BCAST (exactly one cycle): dn_inv_valid = all ports except owner (e.g. owner 0 -> 4'b1110); dn_inv_addr = latched address; pending mask loaded with same target set.
REQ-017 dn_inv_valid zero in all states other than BCAST; dn_inv_addr holds last latched address.
REQ-018 Acks sampled in BCAST and WAIT_ACK: pending[i] cleared when dn_inv_ack[i] high and i is a target.
REQ-019 Acks from owner, from already-cleared targets, or while in IDLE/DONE are ignored without error.
REQ-020 BCAST -> DONE if all targets acked in the BCAST cycle, else -> WAIT_ACK.
REQ-021 WAIT_ACK: timeout counter starts at 0 on entry, increments each cycle; -> DONE when pending, after this cycle's acks, is zero.
REQ-022 Timeout: if counter reaches TIMEOUT_CYC-1 with pending still nonzero, -> DONE and set err_timeout; ack arriving on that same cycle clearing pending wins (no error).
REQ-023 DONE (exactly one cycle): up_req_ack[owner]=1, all other bits 0; next state IDLE.
REQ-024 Originator drops up_req_valid in the cycle after up_req_ack; hub samples requests again only from IDLE.
REQ-025 Requests from non-owner ports arriving while busy are held by the requester and served later; none are lost or merged.
REQ-026 Minimum latency: valid in cycle 0 -> dn_inv_valid cycle 1 -> (acks in cycle 1) up_req_ack cycle 2.
REQ-027 Only one transaction in flight; no pipelining.

Reset
REQ-028 rst high at a clock edge: state=IDLE, rr_ptr=0, pending=0, counter=0, owner=0, up_req_ack=0, dn_inv_valid=0, dn_inv_addr=0, busy=0, err_timeout=0.
REQ-029 Reset mid-transaction aborts it; no up_req_ack issued for the aborted request; it re-arbitrates if still valid after reset.
REQ-030 err_timeout cleared only by rst.

Verification
REQ-031 Port 1 requests 0x0000_1000, targets 0,2,3 ack one cycle after dn_inv_valid=4'b1101 -> dn_inv_addr=0x1000, up_req_ack=4'b0010 two cycles after BCAST, err_timeout=0.
REQ-032 Ports 0 and 2 request same cycle after reset -> port 0 served first (dn_inv_valid=4'b1110), then port 2 (4'b1011); rr_ptr=3 after second DONE.
REQ-033 Owner 3, target 1 never acks, TIMEOUT_CYC=4 -> up_req_ack=4'b1000 exactly 4 cycles after entering WAIT_ACK, err_timeout=1 and stays 1.
REQ-034 Owner 0; owner's own ack and duplicate ack from port 1 injected; port 2 acks late -> completion only after ports 1,2,3 each acked once.
REQ-035 rst asserted in WAIT_ACK -> next cycle all outputs 0, no up_req_ack; request still valid re-broadcasts after reset released.

Source files
------------

// File: rtl/cache_coherence_hub_if.sv
// Coherence hub bundle: per-L1 invalidation requests up, shared invalidate broadcast down.
// The hub uses the slave modport; the L1 side (or a bench) drives through master.
interface cache_coherence_hub_if #(
  parameter int unsigned ADDR_WDT = 32
) ();
  logic [3:0]            up_req_valid;
  logic [4*ADDR_WDT-1:0] up_req_addr;
  logic [3:0]            up_req_ack;
  logic [3:0]            dn_inv_valid;
  logic [ADDR_WDT-1:0]   dn_inv_addr;
  logic [3:0]            dn_inv_ack;

  modport master (
    output up_req_valid, up_req_addr, dn_inv_ack,
    input  up_req_ack, dn_inv_valid, dn_inv_addr
  );

  modport slave (
    input  up_req_valid, up_req_addr, dn_inv_ack,
    output up_req_ack, dn_inv_valid, dn_inv_addr
  );
endinterface

// File: rtl/cache_coherence_hub.sv
// Four-port invalidation hub: round-robin grant, one-cycle broadcast to the other L1s,
// collects their acks (bounded by a timeout) and returns a completion pulse to the owner.
module cache_coherence_hub #(
  parameter int unsigned ADDR_WDT    = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_coherence_hub_if.slave bus,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBcast, StWaitAck, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [3:0]          pending_q, pending_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          up_ack_q, up_ack_d;
  logic [3:0]          dn_valid_q, dn_valid_d;
  logic [ADDR_WDT-1:0] dn_addr_q, dn_addr_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                grant_found;
  logic [1:0]          grant_idx;
  logic [ADDR_WDT-1:0] grant_addr;
  logic [3:0]          pending_left;
  logic [3:0]          owner_oh;

  // Round-robin search starting at rr_ptr_q, wrapping on 2 bits.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!grant_found && bus.up_req_valid[rr_ptr_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_ptr_q + 2'(k);
      end
    end
    grant_addr = '0;
    for (int p = 0; p < 4; p++) begin
      if (grant_idx == 2'(p)) begin
        grant_addr = bus.up_req_addr[p*ADDR_WDT +: ADDR_WDT];
      end
    end
  end

  assign pending_left = pending_q & ~bus.dn_inv_ack;
  assign owner_oh     = 4'b0001 << owner_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    up_ack_d   = 4'b0000;
    dn_valid_d = 4'b0000;
    dn_addr_d  = dn_addr_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          owner_d    = grant_idx;
          dn_valid_d = ~(4'b0001 << grant_idx);
          pending_d  = ~(4'b0001 << grant_idx);
          dn_addr_d  = grant_addr;
          state_d    = StBcast;
        end
      end
      StBcast: begin
        pending_d = pending_left;
        cnt_d     = 8'd0;
        if (pending_left == 4'b0000) begin
          up_ack_d = owner_oh;
          state_d  = StDone;
        end else begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        pending_d = pending_left;
        // A final ack landing on the timeout cycle completes cleanly.
        if (pending_left == 4'b0000) begin
          up_ack_d = owner_oh;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          up_ack_d = owner_oh;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        rr_ptr_d  = owner_q + 2'd1;
        pending_d = 4'b0000;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      pending_q  <= 4'b0000;
      cnt_q      <= 8'd0;
      up_ack_q   <= 4'b0000;
      dn_valid_q <= 4'b0000;
      dn_addr_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      up_ack_q   <= up_ack_d;
      dn_valid_q <= dn_valid_d;
      dn_addr_q  <= dn_addr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.up_req_ack   = up_ack_q;
  assign bus.dn_inv_valid = dn_valid_q;
  assign bus.dn_inv_addr  = dn_addr_q;
  assign busy             = busy_q;
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_cache_coherence_hub.sv
// Randomized scoreboard bench for cache_coherence_hub: a transaction-level model predicts
// grant order, broadcast vectors, completion latency and the sticky timeout flag.
module tb_cache_coherence_hub;

  localparam int          AW    = 32;
  localparam int          TO    = 4;
  localparam logic [7:0]  NEVER = 8'hff;

  typedef struct packed {
    logic        is_ack;
    logic [3:0]  vec;
    logic [31:0] addr;
    logic        err;
    logic        from_start;
    int          gap;
  } ev_t;

  typedef struct packed {
    logic [1:0]      owner;
    logic [3:0][7:0] d;
  } plan_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic err_timeout;

  cache_coherence_hub_if #(.ADDR_WDT(AW)) bus ();

  cache_coherence_hub #(
    .ADDR_WDT   (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    total = 0;
  int    bad   = 0;
  ev_t   sb[$];
  plan_t plan_q[$];
  int    start_cyc = 0;
  logic [1:0]  rr_m  = 2'd0;
  logic        err_m = 1'b0;
  logic [31:0] addr_m [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string msg);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.up_req_valid = 4'b0000;
    sb.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    rr_m  = 2'd0;
    err_m = 1'b0;
  endtask

  // One transaction: target set is everyone but the owner; completion comes one cycle
  // after the last target ack, or after TO cycles of waiting with the error flag.
  task automatic push_txn(input logic [1:0] own, input logic [3:0][7:0] d, input bit first,
                          input bit with_ack);
    plan_t pl;
    ev_t   ev;
    int    maxd;
    logic [3:0] tgt;
    tgt  = 4'hf & ~(4'b0001 << own);
    maxd = 0;
    for (int i = 0; i < 4; i++) begin
      if (tgt[i] && int'(d[i]) > maxd) maxd = int'(d[i]);
    end
    pl.owner = own;
    pl.d     = d;
    plan_q.push_back(pl);
    ev = '{is_ack: 1'b0, vec: tgt, addr: addr_m[own], err: 1'b0, from_start: first,
           gap: (first ? 1 : 2)};
    sb.push_back(ev);
    if (with_ack) begin
      if (maxd > TO) err_m = 1'b1;
      ev = '{is_ack: 1'b1, vec: 4'b0001 << own, addr: addr_m[own], err: err_m,
             from_start: 1'b0, gap: 1 + ((maxd > TO) ? TO : maxd)};
      sb.push_back(ev);
      rr_m = own + 2'd1;
    end
  endtask

  task automatic raise(input logic [3:0] s);
    for (int p = 0; p < 4; p++) bus.up_req_addr[p*AW +: AW] = addr_m[p];
    start_cyc        = cyc;
    bus.up_req_valid = s;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (bus.up_req_valid != 4'b0000 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.up_req_ack != 4'b0000) bus.up_req_valid = bus.up_req_valid & ~bus.up_req_ack;
    end
    if (bus.up_req_valid != 4'b0000) begin
      fail({name, " no completion within cycle budget"});
      do_reset();
      rst = 1'b0;
    end else begin
      @(negedge clk);
      check({name, " idle_busy"}, 64'(busy), 64'(0));
      check({name, " scoreboard_drained"}, 64'(sb.size()), 64'(0));
    end
  endtask

  task automatic run_round(input string name, input logic [3:0] s, input bit rnd,
                           input logic [3:0][7:0] dfix);
    logic [3:0]      rem;
    logic [1:0]      own;
    logic [3:0][7:0] d;
    bit              first;
    bit              found;
    @(negedge clk);
    if (rnd) for (int p = 0; p < 4; p++) addr_m[p] = $urandom;
    rem   = s;
    first = 1'b1;
    while (rem != 4'b0000) begin
      own   = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && rem[(int'(rr_m) + k) % 4]) begin
          own   = 2'((int'(rr_m) + k) % 4);
          found = 1'b1;
        end
      end
      if (rnd) begin
        for (int i = 0; i < 4; i++) begin
          d[i] = ($urandom_range(9) < 8) ? 8'($urandom_range(TO)) :
                                           8'($urandom_range(TO + 3, TO + 1));
        end
      end else begin
        d = dfix;
      end
      push_txn(own, d, first, 1'b1);
      rem[own] = 1'b0;
      first    = 1'b0;
    end
    raise(s);
    wait_drain(name);
  endtask

  // Ack responder: target acks per plan, plus duplicate, owner and idle-time junk acks.
  initial begin
    bit    active;
    int    t;
    plan_t cur;
    logic [3:0] ack;
    active = 1'b0;
    t      = 0;
    cur    = '0;
    bus.dn_inv_ack = 4'b0000;
    forever begin
      @(negedge clk);
      ack = 4'b0000;
      if (rst) begin
        active = 1'b0;
      end else if (bus.dn_inv_valid != 4'b0000) begin
        if (plan_q.size() > 0) begin
          cur    = plan_q.pop_front();
          active = 1'b1;
          t      = 0;
        end
      end else if (bus.up_req_ack != 4'b0000) begin
        active = 1'b0;
      end else if (active) begin
        t++;
      end
      if (active) begin
        for (int i = 0; i < 4; i++) begin
          if (2'(i) == cur.owner)     ack[i] = ($urandom_range(3) == 0);
          else if (int'(cur.d[i]) == t) ack[i] = 1'b1;
          else if (int'(cur.d[i]) < t)  ack[i] = ($urandom_range(2) == 0);
        end
      end else if ($urandom_range(3) == 0) begin
        ack = 4'($urandom_range(15));
      end
      bus.dn_inv_ack = ack;
    end
  end

  // Monitor: every broadcast or completion the DUT presents must match the next expectation.
  initial begin
    ev_t ev;
    int  rc;
    int  last_cyc;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.dn_inv_valid != 4'b0000 || bus.up_req_ack != 4'b0000)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: dn_inv_valid=%b up_req_ack=%b want none (cycle %0d)",
                   bus.dn_inv_valid, bus.up_req_ack, cyc);
        end else begin
          ev = sb.pop_front();
          rc = ev.from_start ? start_cyc : last_cyc;
          if (ev.is_ack) begin
            check("ack_vec", 64'(bus.up_req_ack), 64'(ev.vec));
            check("ack_no_inv", 64'(bus.dn_inv_valid), 64'(0));
            check("ack_err_timeout", 64'(err_timeout), 64'(ev.err));
            check("ack_addr_held", 64'(bus.dn_inv_addr), 64'(ev.addr));
            check("ack_latency", 64'(cyc - rc), 64'(ev.gap));
          end else begin
            check("inv_vec", 64'(bus.dn_inv_valid), 64'(ev.vec));
            check("inv_addr", 64'(bus.dn_inv_addr), 64'(ev.addr));
            check("inv_no_ack", 64'(bus.up_req_ack), 64'(0));
            check("inv_latency", 64'(cyc - rc), 64'(ev.gap));
          end
          check("busy_in_txn", 64'(busy), 64'(1));
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] d;
    bit seen;
    bus.up_req_valid = 4'b0000;
    bus.up_req_addr  = '0;
    for (int p = 0; p < 4; p++) addr_m[p] = 32'h0;

    do_reset();
    check("rst busy", 64'(busy), 64'(0));
    check("rst err_timeout", 64'(err_timeout), 64'(0));
    check("rst dn_inv_valid", 64'(bus.dn_inv_valid), 64'(0));
    check("rst dn_inv_addr", 64'(bus.dn_inv_addr), 64'(0));
    check("rst up_req_ack", 64'(bus.up_req_ack), 64'(0));
    rst = 1'b0;

    // Port 1, targets ack one cycle after the broadcast.
    addr_m[1] = 32'h0000_1000;
    run_round("basic_p1", 4'b0010, 1'b0, {4{8'd1}});

    // Simultaneous ports 0 and 2 after reset, then 0 and 3 to expose the pointer at 3.
    do_reset();
    rst = 1'b0;
    addr_m[0] = 32'h0000_2000;
    addr_m[2] = 32'h0000_2200;
    run_round("rr_p0_p2", 4'b0101, 1'b0, {4{8'd0}});
    addr_m[0] = 32'h0000_3000;
    addr_m[3] = 32'h0000_3300;
    run_round("rr_ptr3", 4'b1001, 1'b0, {4{8'd0}});

    // Owner 3, port 1 never acks.
    addr_m[3] = 32'h0000_4300;
    run_round("timeout_p3", 4'b1000, 1'b0, {8'd0, 8'd0, NEVER, 8'd0});

    // Owner 0, port 2 late, owner and duplicate acks injected by the responder.
    addr_m[0] = 32'h0000_5000;
    run_round("late_ack_p0", 4'b0001, 1'b0, {8'd1, 8'd3, 8'd0, 8'd0});
    check("err_sticky", 64'(err_timeout), 64'(1));

    // Reset while waiting for acks, request stays up and is re-broadcast.
    @(negedge clk);
    addr_m[2] = 32'hABCD_0040;
    push_txn(2'd2, {4{NEVER}}, 1'b1, 1'b0);
    raise(4'b0100);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = (bus.dn_inv_valid != 4'b0000);
    end
    check("rst_mid bcast_seen", 64'(seen), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid busy", 64'(busy), 64'(0));
    check("rst_mid err_timeout", 64'(err_timeout), 64'(0));
    check("rst_mid dn_inv_valid", 64'(bus.dn_inv_valid), 64'(0));
    check("rst_mid dn_inv_addr", 64'(bus.dn_inv_addr), 64'(0));
    check("rst_mid up_req_ack", 64'(bus.up_req_ack), 64'(0));
    rr_m  = 2'd0;
    err_m = 1'b0;
    push_txn(2'd2, {4{8'd0}}, 1'b1, 1'b1);
    rst       = 1'b0;
    start_cyc = cyc;
    wait_drain("rst_mid rearb");

    for (int r = 0; r < 40; r++) begin
      d = '0;
      run_round("random", 4'($urandom_range(15, 1)), 1'b1, d);
    end

    repeat (3) @(negedge clk);
    check("final scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
